// File: rtl/vmem_arb_pkg.sv
// rtl/vmem_arb_pkg.sv - shared types and helpers for the vmem arbiter
package vmem_arb_pkg;

    // Requester ID as stored in the in-flight FIFO
    typedef enum logic {
        VMEM_REQ_VEC = 1'b0,
        VMEM_REQ_SCA = 1'b1
    } vmem_req_id_e;

    // Width of an outstanding counter that must hold 0..max_outstanding inclusive
    function automatic int vmem_cnt_w(input int max_outstanding);
        return $clog2(max_outstanding) + 1;
    endfunction

endpackage

// File: rtl/vmem_arb_id_fifo.sv
// rtl/vmem_arb_id_fifo.sv - ordered FIFO of requester IDs for in-flight transactions
module vmem_arb_id_fifo
    import vmem_arb_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CW = vmem_cnt_w(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          data_i,
    output logic          head_o,
    output logic [CW-1:0] count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DEPTH-1:0] mem_q, mem_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    // Pointer, storage and occupancy update; push ignored when full, pop ignored when empty
    always_comb begin
        do_push  = push_i && (count_q != FULL_CNT);
        do_pop   = pop_i && (count_q != '0);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // State registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/vmem_arbiter.sv
// rtl/vmem_arbiter.sv - round-robin OBI arbiter between vector and scalar memory requesters
module vmem_arbiter
    import vmem_arb_pkg::*;
#(
    parameter int VMEM_W          = 128,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  vec_req_i,
    output logic                  vec_gnt_o,
    input  logic [31:0]           vec_addr_i,
    input  logic                  vec_we_i,
    input  logic [VMEM_W/8-1:0]   vec_be_i,
    input  logic [VMEM_W-1:0]     vec_wdata_i,
    output logic                  vec_rvalid_o,
    output logic [VMEM_W-1:0]     vec_rdata_o,
    output logic                  vec_err_o,
    input  logic                  sca_req_i,
    output logic                  sca_gnt_o,
    input  logic [31:0]           sca_addr_i,
    input  logic                  sca_we_i,
    input  logic [VMEM_W/8-1:0]   sca_be_i,
    input  logic [VMEM_W-1:0]     sca_wdata_i,
    output logic                  sca_rvalid_o,
    output logic [VMEM_W-1:0]     sca_rdata_o,
    output logic                  sca_err_o,
    output logic                  mem_req_o,
    input  logic                  mem_gnt_i,
    output logic [31:0]           mem_addr_o,
    output logic                  mem_we_o,
    output logic [VMEM_W/8-1:0]   mem_be_o,
    output logic [VMEM_W-1:0]     mem_wdata_o,
    input  logic                  mem_rvalid_i,
    input  logic [VMEM_W-1:0]     mem_rdata_i,
    input  logic                  mem_err_i,
    output logic                  proto_err_o
);

    localparam int CW = vmem_cnt_w(MAX_OUTSTANDING);
    localparam logic [CW-1:0] FULL_CNT = CW'(MAX_OUTSTANDING);

    vmem_req_id_e  sel_q, sel_d, sel;
    vmem_req_id_e  last_q, last_d;
    logic          lock_q, lock_d;
    logic          proto_err_q, proto_err_d;
    logic          sel_req;
    logic          handshake;
    logic          resp_ok;
    logic          fifo_head;
    logic [CW-1:0] count;

    // Pick the requester to present: hold a locked selection, else round-robin on contention
    always_comb begin
        sel = VMEM_REQ_VEC;
        if (lock_q) begin
            sel = sel_q;
        end else if (vec_req_i && !sca_req_i) begin
            sel = VMEM_REQ_VEC;
        end else if (!vec_req_i && sca_req_i) begin
            sel = VMEM_REQ_SCA;
        end else if (vec_req_i && sca_req_i) begin
            sel = (last_q == VMEM_REQ_VEC) ? VMEM_REQ_SCA : VMEM_REQ_VEC;
        end
        sel_req = (sel == VMEM_REQ_SCA) ? sca_req_i : vec_req_i;
    end

    // Memory request and field mux; a full ID FIFO blocks new requests regardless of rvalid
    always_comb begin
        mem_req_o   = sel_req && (count != FULL_CNT) && !rst_i;
        mem_addr_o  = vec_addr_i;
        mem_we_o    = vec_we_i;
        mem_be_o    = vec_be_i;
        mem_wdata_o = vec_wdata_i;
        if (mem_req_o && (sel == VMEM_REQ_SCA)) begin
            mem_addr_o  = sca_addr_i;
            mem_we_o    = sca_we_i;
            mem_be_o    = sca_be_i;
            mem_wdata_o = sca_wdata_i;
        end
    end

    // Grants to the presented requester and in-order response routing from the FIFO head
    always_comb begin
        handshake    = mem_req_o && mem_gnt_i;
        vec_gnt_o    = handshake && (sel == VMEM_REQ_VEC);
        sca_gnt_o    = handshake && (sel == VMEM_REQ_SCA);
        resp_ok      = mem_rvalid_i && (count != '0) && !rst_i;
        vec_rvalid_o = resp_ok && !fifo_head;
        sca_rvalid_o = resp_ok && fifo_head;
        vec_rdata_o  = mem_rdata_i;
        sca_rdata_o  = mem_rdata_i;
        vec_err_o    = mem_err_i;
        sca_err_o    = mem_err_i;
    end

    // Next-state for lock, selection, round-robin history and the sticky protocol flag
    always_comb begin
        sel_d       = sel_q;
        lock_d      = lock_q;
        last_d      = last_q;
        proto_err_d = proto_err_q || (mem_rvalid_i && (count == '0));
        if (handshake) begin
            sel_d  = sel;
            last_d = sel;
            lock_d = 1'b0;
        end else if (mem_req_o) begin
            sel_d  = sel;
            lock_d = 1'b1;
        end
    end

    // State registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sel_q       <= VMEM_REQ_VEC;
            lock_q      <= 1'b0;
            last_q      <= VMEM_REQ_VEC;
            proto_err_q <= 1'b0;
        end else begin
            sel_q       <= sel_d;
            lock_q      <= lock_d;
            last_q      <= last_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign proto_err_o = proto_err_q;

    vmem_arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (handshake),
        .pop_i   (resp_ok),
        .data_i  (sel == VMEM_REQ_SCA),
        .head_o  (fifo_head),
        .count_o (count)
    );

endmodule

// File: tb/tb_vmem_arbiter.sv
// tb/tb_vmem_arbiter.sv - scoreboard bench for vmem_arbiter
module tb_vmem_arbiter;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          vec_req_i = 1'b0, sca_req_i = 1'b0;
    logic          vec_gnt_o, sca_gnt_o;
    logic [31:0]   vec_addr_i = '0, sca_addr_i = '0;
    logic          vec_we_i = 1'b0, sca_we_i = 1'b0;
    logic [15:0]   vec_be_i = 16'hFFFF, sca_be_i = 16'hFFFF;
    logic [127:0]  vec_wdata_i = '0, sca_wdata_i = '0;
    logic          vec_rvalid_o, sca_rvalid_o;
    logic [127:0]  vec_rdata_o, sca_rdata_o;
    logic          vec_err_o, sca_err_o;
    logic          mem_req_o;
    logic          mem_gnt_i = 1'b0;
    logic [31:0]   mem_addr_o;
    logic          mem_we_o;
    logic [15:0]   mem_be_o;
    logic [127:0]  mem_wdata_o;
    logic          mem_rvalid_i = 1'b0;
    logic [127:0]  mem_rdata_i = '0;
    logic          mem_err_i = 1'b0;
    logic          proto_err_o;

    int checks = 0;
    int errors = 0;

    typedef struct packed {logic id; logic [31:0] addr;} gnt_t;
    typedef struct packed {logic id; logic [127:0] data; logic err;} rsp_t;
    gnt_t gq[$];
    rsp_t rq[$];
    gnt_t g;
    rsp_t r;

    vmem_arbiter #(.VMEM_W(128), .MAX_OUTSTANDING(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .vec_req_i(vec_req_i), .vec_gnt_o(vec_gnt_o), .vec_addr_i(vec_addr_i),
        .vec_we_i(vec_we_i), .vec_be_i(vec_be_i), .vec_wdata_i(vec_wdata_i),
        .vec_rvalid_o(vec_rvalid_o), .vec_rdata_o(vec_rdata_o), .vec_err_o(vec_err_o),
        .sca_req_i(sca_req_i), .sca_gnt_o(sca_gnt_o), .sca_addr_i(sca_addr_i),
        .sca_we_i(sca_we_i), .sca_be_i(sca_be_i), .sca_wdata_i(sca_wdata_i),
        .sca_rvalid_o(sca_rvalid_o), .sca_rdata_o(sca_rdata_o), .sca_err_o(sca_err_o),
        .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o),
        .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
        .proto_err_o(proto_err_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [127:0] dat(input logic [31:0] a);
        return {a, ~a, a ^ 32'h5A5A_5A5A, 32'hC0DE_0000 | a};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic vr, input logic [31:0] va, input logic sr,
                          input logic [31:0] sa, input logic gn, input logic rv,
                          input logic [31:0] ra, input logic er);
        vec_req_i    = vr;
        vec_addr_i   = va;
        sca_req_i    = sr;
        sca_addr_i   = sa;
        mem_gnt_i    = gn;
        mem_rvalid_i = rv;
        mem_rdata_i  = rv ? dat(ra) : '0;
        mem_err_i    = er;
    endtask

    task automatic idle();
        set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Expected grant and response for a transaction granted this cycle
    task automatic expect_txn(input logic id, input logic [31:0] addr, input logic er);
        gq.push_back('{id: id, addr: addr});
        rq.push_back('{id: id, data: dat(addr), err: er});
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        idle();
        gq.delete();
        rq.delete();
        tick();
        rst_i = 1'b0;
    endtask

    // Monitor: pops expected grants and responses whenever the DUT presents them
    initial begin
        forever begin
            @(negedge clk_i);
            if (!rst_i) begin
                if (vec_gnt_o || sca_gnt_o) begin
                    check("gnt_both", {vec_gnt_o, sca_gnt_o} == 2'b11, 1'b0);
                    if (gq.size() == 0) begin
                        check("gnt_unexpected", {vec_gnt_o, sca_gnt_o}, 2'b00);
                    end else begin
                        g = gq.pop_front();
                        check("gnt_id", sca_gnt_o, g.id);
                        check("gnt_addr", mem_addr_o, g.addr);
                    end
                end
                if (vec_rvalid_o || sca_rvalid_o) begin
                    check("rsp_both", {vec_rvalid_o, sca_rvalid_o} == 2'b11, 1'b0);
                    if (rq.size() == 0) begin
                        check("rsp_unexpected", {vec_rvalid_o, sca_rvalid_o}, 2'b00);
                    end else begin
                        r = rq.pop_front();
                        check("rsp_id", sca_rvalid_o, r.id);
                        check("rsp_data", r.id ? sca_rdata_o : vec_rdata_o, r.data);
                        check("rsp_err", r.id ? sca_err_o : vec_err_o, r.err);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state: request held high but outputs forced low
        vec_req_i = 1'b1;
        #2;
        check("rst_mem_req", mem_req_o, 1'b0);
        check("rst_vec_gnt", vec_gnt_o, 1'b0);
        check("rst_proto", proto_err_o, 1'b0);
        idle();
        tick();
        tick();
        rst_i = 1'b0;

        // vec alone: 4 reads, responses two cycles after each grant
        set_in(1, 32'h100, 0, 0, 1, 0, 0, 0); expect_txn(0, 32'h100, 0);
        @(negedge clk_i); check("t1_req", mem_req_o, 1'b1); tick();
        set_in(1, 32'h110, 0, 0, 1, 0, 0, 0); expect_txn(0, 32'h110, 0); tick();
        set_in(1, 32'h120, 0, 0, 1, 1, 32'h100, 0); expect_txn(0, 32'h120, 0); tick();
        set_in(1, 32'h130, 0, 0, 1, 1, 32'h110, 0); expect_txn(0, 32'h130, 0); tick();
        set_in(0, 0, 0, 0, 0, 1, 32'h120, 0); tick();
        set_in(0, 0, 0, 0, 0, 1, 32'h130, 0); tick();
        idle(); tick();

        // both requesting: sca, vec, sca, vec
        do_reset();
        set_in(1, 32'h200, 1, 32'h300, 1, 0, 0, 0); expect_txn(1, 32'h300, 0); tick();
        set_in(1, 32'h200, 1, 32'h310, 1, 0, 0, 0); expect_txn(0, 32'h200, 0); tick();
        set_in(1, 32'h210, 1, 32'h310, 1, 0, 0, 0); expect_txn(1, 32'h310, 0); tick();
        set_in(1, 32'h210, 1, 32'h320, 1, 0, 0, 0); expect_txn(0, 32'h210, 0); tick();
        set_in(0, 0, 0, 0, 0, 1, 32'h300, 0); tick();
        set_in(0, 0, 0, 0, 0, 1, 32'h200, 0); tick();
        set_in(0, 0, 0, 0, 0, 1, 32'h310, 0); tick();
        set_in(0, 0, 0, 0, 0, 1, 32'h210, 0); tick();
        idle(); tick();

        // lock: vec stalls 3 cycles, sca rises meanwhile and is a write
        do_reset();
        sca_we_i    = 1'b1;
        sca_be_i    = 16'h0F0F;
        sca_wdata_i = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_FEED_F00D;
        set_in(1, 32'h400, 0, 0, 0, 0, 0, 0);
        @(negedge clk_i); check("t3_addr0", mem_addr_o, 32'h400); check("t3_req0", mem_req_o, 1'b1); tick();
        set_in(1, 32'h400, 1, 32'h500, 0, 0, 0, 0);
        @(negedge clk_i); check("t3_addr1", mem_addr_o, 32'h400); check("t3_we1", mem_we_o, 1'b0); tick();
        set_in(1, 32'h400, 1, 32'h500, 0, 0, 0, 0);
        @(negedge clk_i); check("t3_addr2", mem_addr_o, 32'h400); tick();
        set_in(1, 32'h400, 1, 32'h500, 1, 0, 0, 0); expect_txn(0, 32'h400, 0); tick();
        set_in(0, 0, 1, 32'h500, 1, 0, 0, 0); expect_txn(1, 32'h500, 1);
        @(negedge clk_i);
        check("t3_we", mem_we_o, 1'b1);
        check("t3_be", mem_be_o, 16'h0F0F);
        check("t3_wdata", mem_wdata_o, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_FEED_F00D);
        tick();
        set_in(0, 0, 0, 0, 0, 1, 32'h400, 0); tick();
        set_in(0, 0, 0, 0, 0, 1, 32'h500, 1); tick();
        idle(); sca_we_i = 1'b0; sca_be_i = 16'hFFFF; sca_wdata_i = '0; tick();

        // full: 4 grants, 5th blocked even with rvalid in the same cycle
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_in(1, 32'h600 + 32'(16 * i), 0, 0, 1, 0, 0, 0);
            expect_txn(0, 32'h600 + 32'(16 * i), 0);
            tick();
        end
        set_in(1, 32'h640, 0, 0, 1, 1, 32'h600, 0);
        @(negedge clk_i);
        check("t4_full_req", mem_req_o, 1'b0);
        check("t4_full_gnt", vec_gnt_o, 1'b0);
        check("t4_full_addr", mem_addr_o, 32'h640);
        check("t4_full_rvalid", vec_rvalid_o, 1'b1);
        tick();
        set_in(1, 32'h640, 0, 0, 1, 1, 32'h610, 0); expect_txn(0, 32'h640, 0);
        @(negedge clk_i); check("t4_resume_req", mem_req_o, 1'b1); tick();
        set_in(0, 0, 0, 0, 0, 1, 32'h620, 0); tick();
        set_in(0, 0, 0, 0, 0, 1, 32'h630, 0); tick();
        set_in(0, 0, 0, 0, 0, 1, 32'h640, 0); tick();
        idle(); tick();

        // stray rvalid with nothing outstanding
        set_in(0, 0, 0, 0, 0, 1, 32'h999, 0);
        @(negedge clk_i);
        check("t5_vec_rvalid", vec_rvalid_o, 1'b0);
        check("t5_sca_rvalid", sca_rvalid_o, 1'b0);
        check("t5_proto_pre", proto_err_o, 1'b0);
        tick();
        idle();
        @(negedge clk_i); check("t5_proto_set", proto_err_o, 1'b1); tick();
        @(negedge clk_i); check("t5_proto_sticky", proto_err_o, 1'b1);
        tick();
        rst_i = 1'b1;
        vec_req_i = 1'b1;
        #1;
        check("t5_proto_clr", proto_err_o, 1'b0);
        check("t5_rst_req", mem_req_o, 1'b0);
        tick();
        idle();
        rst_i = 1'b0;

        // reset with 3 outstanding, then fresh traffic
        set_in(1, 32'h700, 0, 0, 1, 0, 0, 0); expect_txn(0, 32'h700, 0); tick();
        set_in(1, 32'h710, 0, 0, 1, 0, 0, 0); expect_txn(0, 32'h710, 0); tick();
        set_in(1, 32'h720, 0, 0, 1, 0, 0, 0); expect_txn(0, 32'h720, 0); tick();
        rst_i = 1'b1;
        gq.delete();
        rq.delete();
        set_in(1, 32'h730, 1, 32'h734, 1, 1, 32'h700, 0);
        #1;
        check("t6_req", mem_req_o, 1'b0);
        check("t6_vec_gnt", vec_gnt_o, 1'b0);
        check("t6_sca_gnt", sca_gnt_o, 1'b0);
        check("t6_vec_rvalid", vec_rvalid_o, 1'b0);
        check("t6_sca_rvalid", sca_rvalid_o, 1'b0);
        tick();
        idle();
        rst_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_in(1, 32'h800 + 32'(16 * i), 0, 0, 1, 0, 0, 0);
            expect_txn(0, 32'h800 + 32'(16 * i), 0);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            set_in(0, 0, 0, 0, 0, 1, 32'h800 + 32'(16 * i), 0);
            tick();
        end
        idle(); tick();
        @(negedge clk_i);
        check("end_proto", proto_err_o, 1'b0);
        check("end_gq_empty", 128'(gq.size()), 128'd0);
        check("end_rq_empty", 128'(rq.size()), 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
